// File: rtl/imem_loader.sv
// imem_loader: writes a valid/ready byte stream into consecutive imem bytes and holds the CPU meanwhile.
// Define LOADER_CHECKSUM_EN to require one trailing XOR checksum byte after the payload.
module imem_loader #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W:0]   len_bytes,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err,
  output logic [ADDR_W:0]   bytes_loaded
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MEM_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, bytes_q, bytes_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              err_q;
  logic              beat, load_beat, last_beat, start_idle, len_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  assign beat       = in_valid & in_ready;
  assign load_beat  = beat & (state_q == S_LOAD);
  assign bytes_d    = bytes_q + (ADDR_W+1)'(1);
  assign last_beat  = load_beat & (bytes_d == len_q);
  assign start_idle = start & (state_q == S_IDLE);
  assign len_bad    = len_bytes > LEN_MAX;
  // Pointer wraps at MEM_BYTES, which need not be a power of two.
  assign ptr_d      = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge R) begin
    if (!R) state_q <= S_IDLE;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !len_bad)
          state_d = (len_bytes == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_beat) state_d = S_CHECK;
`else
        if (last_beat) state_d = S_DONE;
`endif
      end
      S_CHECK: if (beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_LOAD, S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      len_q       <= '0;
      bytes_q     <= '0;
      ptr_q       <= BASE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (start_idle) begin
        if (len_bad) begin
          err_q <= 1'b1;
        end else begin
          err_q   <= 1'b0;
          len_q   <= len_bytes;
          bytes_q <= '0;
          ptr_q   <= BASE;
`ifdef LOADER_CHECKSUM_EN
          xor_q   <= '0;
`endif
        end
      end
      if (load_beat) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= ptr_q;
        mem_wdata_q <= in_byte;
        ptr_q       <= ptr_d;
        bytes_q     <= bytes_d;
`ifdef LOADER_CHECKSUM_EN
        xor_q       <= xor_q ^ in_byte;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      // The checksum byte is consumed but never written to imem.
      if (beat && state_q == S_CHECK && in_byte != xor_q) err_q <= 1'b1;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign err          = err_q;
  assign bytes_loaded = bytes_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0 and base 510) checked every cycle against a counter-based model.
module tb_imem_loader;
  localparam int MB = 512;
  localparam int AW = 9;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0, R = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [AW:0] len_bytes = '0;
  logic [7:0]  in_byte = '0;
  logic [1:0]  in_ready, mem_we, busy, done, cpu_hold, err;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0][7:0]    mem_wdata;
  logic [1:0][AW:0]   bytes_loaded;

  int checks = 0, errors = 0;
  int base[2] = '{0, 510};

  // model: bytes still to accept, checksum pending, done pulse, counters
  int         m_left[2], m_bytes[2], e_addr[2], e_data[2];
  bit         m_chk[2], m_done[2], m_err[2], e_we[2];
  logic [7:0] m_xor[2];
  bit [7:0]   dmem[2][MB];
  bit [7:0]   xmem[2][MB];

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(MB), .ADDR_W(AW), .BASE_ADDR(0)) u0 (
    .clk(clk), .R(R), .start(start), .len_bytes(len_bytes), .in_valid(in_valid),
    .in_byte(in_byte), .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .busy(busy[0]), .done(done[0]), .cpu_hold(cpu_hold[0]),
    .err(err[0]), .bytes_loaded(bytes_loaded[0]));

  imem_loader #(.MEM_BYTES(MB), .ADDR_W(AW), .BASE_ADDR(510)) u1 (
    .clk(clk), .R(R), .start(start), .len_bytes(len_bytes), .in_valid(in_valid),
    .in_byte(in_byte), .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .busy(busy[1]), .done(done[1]), .cpu_hold(cpu_hold[1]),
    .err(err[1]), .bytes_loaded(bytes_loaded[1]));

  always @(posedge clk) begin
    if (mem_we[0]) dmem[0][mem_addr[0]] <= mem_wdata[0];
    if (mem_we[1]) dmem[1][mem_addr[1]] <= mem_wdata[1];
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_chk[k] = 0; m_done[k] = 0; m_err[k] = 0; m_bytes[k] = 0;
      e_we[k] = 0; e_addr[k] = base[k]; e_data[k] = 0; m_xor[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      e_we[k] = 0;
      if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_left[k] == 0 && !m_chk[k]) begin
        if (start) begin
          if (int'(len_bytes) > MB) m_err[k] = 1;
          else begin
            m_err[k] = 0; m_bytes[k] = 0; m_xor[k] = '0;
            if (len_bytes == 0) m_done[k] = 1;
            else m_left[k] = int'(len_bytes);
          end
        end
      end else if (m_left[k] > 0) begin
        if (in_valid) begin
          e_we[k] = 1;
          e_addr[k] = (base[k] + m_bytes[k]) % MB;
          e_data[k] = int'(in_byte);
          xmem[k][e_addr[k]] = in_byte;
          m_bytes[k]++;
          m_xor[k] ^= in_byte;
          m_left[k]--;
          if (m_left[k] == 0) begin
            if (CHK) m_chk[k] = 1;
            else m_done[k] = 1;
          end
        end
      end else if (in_valid) begin
        if (in_byte != m_xor[k]) m_err[k] = 1;
        m_chk[k] = 0;
        m_done[k] = 1;
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      bit act;
      act = (m_left[k] > 0) || m_chk[k];
      chk("in_ready", k, in_ready[k], act);
      chk("busy", k, busy[k], act || m_done[k]);
      chk("cpu_hold", k, cpu_hold[k], act || m_done[k]);
      chk("done", k, done[k], m_done[k]);
      chk("err", k, err[k], m_err[k]);
      chk("bytes_loaded", k, bytes_loaded[k], m_bytes[k]);
      chk("mem_we", k, mem_we[k], e_we[k]);
      chk("mem_addr", k, mem_addr[k], e_addr[k]);
      chk("mem_wdata", k, mem_wdata[k], e_data[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    R = 1'b0;
    #1;
    model_reset();
    model_check();
    @(negedge clk);
    R = 1'b1;
  endtask

  function automatic logic [7:0] xr(input bq_t d);
    logic [7:0] x = '0;
    foreach (d[i]) x ^= d[i];
    return x;
  endfunction

  // vpct < 0: in_valid alternates 1,0,1,...; nbeats < 0: payload plus checksum if enabled
  task automatic load(input int len, input bq_t d, input logic [7:0] ck, input int vpct, input int nbeats);
    int i, guard, nb;
    bit rdy;
    nb = (nbeats < 0) ? d.size() + int'(CHK) : nbeats;
    start = 1'b1; len_bytes = (AW+1)'(len);
    in_valid = 1'($urandom); in_byte = 8'($urandom);
    cyc();
    start = 1'b0;
    i = 0; guard = 0;
    while (i < nb && guard < 3000) begin
      in_valid = (vpct < 0) ? (guard % 2 == 0) : (int'($urandom_range(99)) < vpct);
      in_byte  = (i < d.size()) ? d[i] : ck;
      start    = ($urandom_range(9) == 0);
      len_bytes = (AW+1)'($urandom);
      rdy = (m_left[0] > 0) || m_chk[0];
      cyc();
      if (in_valid && rdy) i++;
      guard++;
    end
    start = 1'b0; in_valid = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    bq_t q;
    int len, bad;
    #2;
    model_reset();
    do_reset();

    q = '{8'h82, 8'h10, 8'h20, 8'h05};
    load(4, q, xr(q), 100, -1);

    q = '{8'h11, 8'h22, 8'h33};
    load(3, q, xr(q), -1, -1);
    chk("t2_bytes_loaded", 0, bytes_loaded[0], 3);

    q = {};
    load(513, q, 8'h00, 100, 0);
    chk("t4_err_len513", 0, err[0], 1);
    load(1023, q, 8'h00, 100, 0);
    load(0, q, 8'h00, 100, 0);
    chk("t4_err_len0", 0, err[0], 0);

    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    load(6, q, 8'h00, 100, 2);
    do_reset();
    q = '{8'h5A, 8'hC3};
    load(2, q, xr(q), 100, -1);

`ifdef LOADER_CHECKSUM_EN
    q = '{8'h01, 8'h02, 8'h04};
    load(3, q, 8'h07, 100, -1);
    chk("t6_err_good_sum", 0, err[0], 0);
    load(3, q, 8'h06, 100, -1);
    chk("t7_err_bad_sum", 0, err[0], 1);
`endif

    repeat (8) begin
      len = $urandom_range(1, 40);
      q = {};
      repeat (len) q.push_back(8'($urandom));
      load(len, q, ($urandom_range(3) == 0) ? 8'($urandom) : xr(q), $urandom_range(30, 100), -1);
    end

    q = {};
    repeat (MB) q.push_back(8'($urandom));
    load(MB, q, xr(q), 100, -1);

    for (int k = 0; k < 2; k++) begin
      bad = 0;
      for (int a = 0; a < MB; a++) if (dmem[k][a] != xmem[k][a]) bad++;
      chk("imem_contents", k, bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
